// File: rtl/sonic_v1_15_nios_base_cpu_oci_dct_drain_if.sv
// Packed-trace load port and 2-bit valid/ready trace port of the DCT drain.
// The slave modport is the drain itself; the master is the packer/trace sink side.
interface sonic_v1_15_nios_base_cpu_oci_dct_drain_if;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_load;
    logic        dct_ready;
    logic [1:0]  tr_field;
    logic        tr_valid;
    logic        tr_ready;
    logic        tr_last;

    modport slave (
        input  dct_buffer, dct_count, dct_load, tr_ready,
        output dct_ready, tr_field, tr_valid, tr_last
    );

    modport master (
        output dct_buffer, dct_count, dct_load, tr_ready,
        input  dct_ready, tr_field, tr_valid, tr_last
    );
endinterface

// File: rtl/sonic_v1_15_nios_base_cpu_oci_dct_drain.sv
// Serializes a packed DCT trace word (up to fifteen 2-bit fields, LSB field
// first) onto a valid/ready trace port; reports drain completion at end of test.
module sonic_v1_15_nios_base_cpu_oci_dct_drain (
    input  logic                                      clk,
    input  logic                                      reset_n,
    sonic_v1_15_nios_base_cpu_oci_dct_drain_if.slave  dct,
    input  logic                                      test_ending,
    output logic                                      test_done,
    output logic                                      overflow,
    output logic [15:0]                               fields_emitted
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [29:0] shreg;
    logic [3:0]  rem;
    logic        ready;
    logic        accept;
    logic        handshake;

    // A reload is accepted during the final-field handshake so streams stay gap-free.
    assign ready     = (state == IDLE) || ((state == EMIT) && (rem == 4'd1) && dct.tr_ready);
    assign accept    = dct.dct_load && ready;
    assign handshake = (state == EMIT) && dct.tr_ready;

    assign dct.dct_ready = ready;
    assign dct.tr_valid  = (state == EMIT);
    assign dct.tr_field  = (state == EMIT) ? shreg[1:0] : 2'b00;
    assign dct.tr_last   = (state == EMIT) && (rem == 4'd1);
    assign test_done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = (dct.dct_count != 4'd0) ? EMIT : IDLE;
                else if (test_ending)
                    state_next = DONE;
            end
            EMIT: begin
                if (handshake && (rem == 4'd1)) begin
                    if (accept)
                        state_next = (dct.dct_count != 4'd0) ? EMIT : IDLE;
                    else if (test_ending)
                        state_next = DONE;
                    else
                        state_next = IDLE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shreg          <= 30'd0;
            rem            <= 4'd0;
            fields_emitted <= 16'd0;
            overflow       <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                shreg <= dct.dct_buffer;
                rem   <= dct.dct_count;
            end else if (handshake) begin
                shreg <= {2'b00, shreg[29:2]};
                rem   <= rem - 4'd1;
            end
            if (handshake && (fields_emitted != 16'hFFFF))
                fields_emitted <= fields_emitted + 16'd1;
            if (dct.dct_load && !ready)
                overflow <= 1'b1;
        end
    end

endmodule
